// File: rtl/icache_pkg.sv
// icache_pkg: shared types and geometry for the instruction-cache refill path.
//   fill_state_t       refill FSM states (IDLE, REQ, FILL, WRITE)
//   BLOCK_WIDTH        cache block width in bits
//   BEAT_WIDTH         memory read data width per beat
//   BEAT_COUNT         beats per block
//   BLOCK_OFFSET_WIDTH byte-offset bits inside one block (zeroed in requests)
//   CNT_WIDTH          beat counter width
package icache_pkg;

  localparam int BLOCK_WIDTH        = 512;
  localparam int BEAT_WIDTH         = 64;
  localparam int BEAT_COUNT         = BLOCK_WIDTH / BEAT_WIDTH;
  localparam int BLOCK_OFFSET_WIDTH = $clog2(BLOCK_WIDTH / 8);
  localparam int CNT_WIDTH          = $clog2(BEAT_COUNT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    FILL  = 2'd2,
    WRITE = 2'd3
  } fill_state_t;

endpackage

// File: rtl/icache_fill_if.sv
// icache_fill_if: instruction-memory read port seen by the refill controller.
//   req    read request valid          (controller -> memory)
//   addr   block-aligned request address (controller -> memory)
//   ready  memory accepts the request  (memory -> controller)
//   rvalid read beat valid             (memory -> controller)
//   rdata  read beat data              (memory -> controller)
//   rerr   beat error, qualified by rvalid; present only with ICACHE_FILL_ERR_EN
// Modports: master = refill controller, slave = memory.
interface icache_fill_if
  import icache_pkg::*;
#(
  parameter int ADDR_WIDTH = 64
);

  logic                  req;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  ready;
  logic                  rvalid;
  logic [BEAT_WIDTH-1:0] rdata;

`ifdef ICACHE_FILL_ERR_EN
  logic                  rerr;

  modport master (output req, addr, input ready, rvalid, rdata, rerr);
  modport slave  (input req, addr, output ready, rvalid, rdata, rerr);
`else
  modport master (output req, addr, input ready, rvalid, rdata);
  modport slave  (input req, addr, output ready, rvalid, rdata);
`endif

endinterface

// File: rtl/icache_fill_buffer.sv
// icache_fill_buffer: beat counter plus block assembly register.
//   clk_i, arst_i  clock, asynchronous active-high reset
//   clear_i        zero the counter and the block (start of a new fill)
//   load_i         store beat_i at the current beat slot and advance
//   beat_i         incoming beat data
//   block_o        assembled block, beat 0 in the LSBs
//   last_o         the counter points at the final beat slot
module icache_fill_buffer
  import icache_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   arst_i,
  input  logic                   clear_i,
  input  logic                   load_i,
  input  logic [BEAT_WIDTH-1:0]  beat_i,
  output logic [BLOCK_WIDTH-1:0] block_o,
  output logic                   last_o
);

  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [BLOCK_WIDTH-1:0] block_q, block_d;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_d   = cnt_q;
    block_d = block_q;
    if (clear_i) begin
      cnt_d   = '0;
      block_d = '0;
    end else if (load_i) begin
      block_d[cnt_q*BEAT_WIDTH +: BEAT_WIDTH] = beat_i;
      cnt_d = cnt_q + CNT_WIDTH'(1); // wraps to 0 after the last beat
    end
  end

  // NOTE: state updates use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  // NOTE: the block register is reset even though it is wide, because a reset
  // must discard a partial block and present zeros on block_o.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      cnt_q   <= '0;
      block_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      block_q <= block_d;
    end
  end

  assign block_o = block_q;
  assign last_o  = (cnt_q == CNT_WIDTH'(BEAT_COUNT - 1));

endmodule

// File: rtl/icache_fill.sv
// icache_fill: refill controller for the direct-mapped instruction cache.
// On a miss it latches the fetch address, issues one block-aligned read,
// assembles BEAT_COUNT beats and writes the block for exactly one cycle,
// stalling fetch until then.
//   clk_i, arst_i  clock, asynchronous active-high reset
//   miss_i         cache miss for the current fetch
//   addr_i         current fetch address
//   mem            instruction-memory read port (master side)
//   fill_addr_o    latched miss address for cache index/tag on write
//   block_o        assembled block
//   write_en_o     one-cycle cache write strobe
//   stall_o        fetch stall
//   fill_err_o     one-cycle error pulse replacing write_en_o (optional)
// Optional feature macro: ICACHE_FILL_ERR_EN adds mem.rerr and fill_err_o.
module icache_fill
  import icache_pkg::*;
#(
  parameter int ADDR_WIDTH = 64
)(
  input  logic                   clk_i,
  input  logic                   arst_i,
  input  logic                   miss_i,
  input  logic [ADDR_WIDTH-1:0]  addr_i,
  icache_fill_if.master          mem,
  output logic [ADDR_WIDTH-1:0]  fill_addr_o,
  output logic [BLOCK_WIDTH-1:0] block_o,
  output logic                   write_en_o,
`ifdef ICACHE_FILL_ERR_EN
  output logic                   fill_err_o,
`endif
  output logic                   stall_o
);

  fill_state_t           state_q, state_d;
  logic [ADDR_WIDTH-1:0] fill_addr_q, fill_addr_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                  mem_req_q, mem_req_d;
  logic                  write_en_q, write_en_d;
  logic                  buf_clear, buf_load, buf_last;
  logic                  fill_bad; // current fill carries an errored beat

  icache_fill_buffer u_buffer (
    .clk_i   (clk_i),
    .arst_i  (arst_i),
    .clear_i (buf_clear),
    .load_i  (buf_load),
    .beat_i  (mem.rdata),
    .block_o (block_o),
    .last_o  (buf_last)
  );

`ifdef ICACHE_FILL_ERR_EN
  logic err_q, err_d;
  logic fill_err_q, fill_err_d;

  // Sticky over the burst including the beat arriving this cycle.
  assign fill_bad = err_q | mem.rerr;

  always_comb begin
    err_d      = err_q;
    fill_err_d = 1'b0;
    if (state_q == FILL && mem.rvalid) begin
      err_d = fill_bad;
      if (buf_last) fill_err_d = fill_bad;
    end
    if (state_q == WRITE) err_d = 1'b0;
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      err_q      <= 1'b0;
      fill_err_q <= 1'b0;
    end else begin
      err_q      <= err_d;
      fill_err_q <= fill_err_d;
    end
  end

  assign fill_err_o = fill_err_q;
`else
  assign fill_bad = 1'b0;
`endif

  // Next-state and registered-output logic. The memory outputs are computed
  // one cycle ahead so they are flops aligned with the state they belong to.
  always_comb begin
    state_d     = state_q;
    fill_addr_d = fill_addr_q;
    mem_addr_d  = mem_addr_q;
    mem_req_d   = mem_req_q;
    write_en_d  = 1'b0;
    buf_clear   = 1'b0;
    buf_load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (miss_i) begin
          state_d     = REQ;
          fill_addr_d = addr_i;
          mem_addr_d  = {addr_i[ADDR_WIDTH-1:BLOCK_OFFSET_WIDTH],
                         {BLOCK_OFFSET_WIDTH{1'b0}}};
          mem_req_d   = 1'b1;
          buf_clear   = 1'b1;
        end
      end
      REQ: begin
        if (mem.ready) begin
          state_d   = FILL;
          mem_req_d = 1'b0;
        end
      end
      FILL: begin
        if (mem.rvalid) begin
          buf_load = 1'b1;
          if (buf_last) begin
            state_d    = WRITE;
            write_en_d = ~fill_bad;
          end
        end
      end
      WRITE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q     <= IDLE;
      fill_addr_q <= '0;
      mem_addr_q  <= '0;
      mem_req_q   <= 1'b0;
      write_en_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_addr_q <= fill_addr_d;
      mem_addr_q  <= mem_addr_d;
      mem_req_q   <= mem_req_d;
      write_en_q  <= write_en_d;
    end
  end

  assign mem.req     = mem_req_q;
  assign mem.addr    = mem_addr_q;
  assign fill_addr_o = fill_addr_q;
  assign write_en_o  = write_en_q;
  assign stall_o     = miss_i | (state_q != IDLE);

endmodule
